// File: rtl/ofm_tile_scheduler.sv
// Walks one conv layer's OFM tile by tile (col, then row, then filter group), pulsing tile_start and waiting for tile_done.
// Optional wait-phase watchdog enabled by defining TILE_TIMEOUT_EN.
module ofm_tile_scheduler #(
  parameter int SYSTOLIC_SIZE  = 16,
  parameter int OFM_SIZE       = 414,
  parameter int NO_FILTER      = 16,
  parameter int ADDR_WIDTH     = 22,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int NCOL  = (OFM_SIZE + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE,
  localparam int NGRP  = NO_FILTER / SYSTOLIC_SIZE,
  localparam int CNT_W = $clog2(SYSTOLIC_SIZE + 1),
  localparam int COL_W = (NCOL > 1) ? $clog2(NCOL) : 1,
  localparam int ROW_W = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1,
  localparam int GRP_W = $clog2(NGRP) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  tile_done,
  output logic                  tile_start,
  output logic [ADDR_WIDTH-1:0] ofm_base_addr,
  output logic [CNT_W-1:0]      tile_valid_cnt,
  output logic [COL_W-1:0]      tile_col,
  output logic [ROW_W-1:0]      tile_row,
  output logic [GRP_W-1:0]      filter_grp,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int     LAST_CNT   = OFM_SIZE - (NCOL - 1) * SYSTOLIC_SIZE;
  // Address jumps: end of a row to the next row start, end of a group to the next group start.
  localparam longint GRP_STEP_L = longint'(SYSTOLIC_SIZE) * OFM_SIZE * OFM_SIZE
                                - longint'(OFM_SIZE - 1) * OFM_SIZE
                                - longint'(NCOL - 1) * SYSTOLIC_SIZE;

  localparam logic [ADDR_WIDTH-1:0] COL_STEP = ADDR_WIDTH'(SYSTOLIC_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(LAST_CNT);
  localparam logic [ADDR_WIDTH-1:0] GRP_STEP = ADDR_WIDTH'(GRP_STEP_L);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(SYSTOLIC_SIZE);
  localparam logic [CNT_W-1:0]      TAIL_CNT = CNT_W'(LAST_CNT);
  localparam logic [COL_W-1:0]      COL_LAST = COL_W'(NCOL - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(OFM_SIZE - 1);
  localparam logic [GRP_W-1:0]      GRP_LAST = GRP_W'(NGRP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ADVANCE,
    S_FINISH
  } state_e;

  state_e                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [GRP_W-1:0]        grp_q, grp_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    last_tile;

`ifdef TILE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wcnt_q, wcnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    grp_d     = grp_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
`ifdef TILE_TIMEOUT_EN
    wcnt_d    = wcnt_q;
    err_d     = err_q;
`endif
    last_tile = (col_q == COL_LAST) && (row_q == ROW_LAST) && (grp_q == GRP_LAST);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          col_d   = '0;
          row_d   = '0;
          grp_d   = '0;
          addr_d  = '0;
          cnt_d   = (NCOL == 1) ? TAIL_CNT : FULL_CNT;
          busy_d  = 1'b1;
`ifdef TILE_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef TILE_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      S_WAIT: begin
        if (tile_done) begin
          state_d = S_ADVANCE;
        end
`ifdef TILE_TIMEOUT_EN
        else if (wcnt_q == TO_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          wcnt_d  = wcnt_q + TO_W'(1);
        end
`endif
      end
      S_ADVANCE: begin
        if (last_tile) begin
          state_d = S_FINISH;
          busy_d  = 1'b0;
        end else begin
          state_d = S_ISSUE;
          if (col_q != COL_LAST) begin
            col_d  = col_q + COL_W'(1);
            addr_d = addr_q + COL_STEP;
          end else begin
            col_d = '0;
            if (row_q != ROW_LAST) begin
              row_d  = row_q + ROW_W'(1);
              addr_d = addr_q + ROW_STEP;
            end else begin
              row_d  = '0;
              grp_d  = grp_q + GRP_W'(1);
              addr_d = addr_q + GRP_STEP;
            end
          end
          cnt_d = (col_d == COL_LAST) ? TAIL_CNT : FULL_CNT;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      grp_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
`ifdef TILE_TIMEOUT_EN
      wcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      grp_q   <= grp_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
`ifdef TILE_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign tile_start     = (state_q == S_ISSUE);
  assign done           = (state_q == S_FINISH);
  assign busy           = busy_q;
  assign ofm_base_addr  = addr_q;
  assign tile_valid_cnt = cnt_q;
  assign tile_col       = col_q;
  assign tile_row       = row_q;
  assign filter_grp     = grp_q;
`ifdef TILE_TIMEOUT_EN
  assign error          = err_q;
`else
  assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_ofm_tile_scheduler.sv
// Scoreboard bench: a small-config instance (4/5/8) for sweep, ignored-event, reset and timeout scenarios, plus a default-config instance for the full-layer sweep.
module tb_ofm_tile_scheduler;
  localparam int S_SS = 4, S_OFM = 5, S_NF = 8, S_TO = 10;
  localparam int D_SS = 16, D_OFM = 414, D_NF = 16;
  localparam int AW = 22;

  typedef struct packed {
    int addr;
    int cnt;
    int col;
    int row;
    int grp;
  } tile_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          s_start, s_tile_done, s_tile_start, s_busy, s_done, s_error;
  logic [AW-1:0] s_addr;
  logic [2:0]    s_cnt;
  logic [0:0]    s_col;
  logic [2:0]    s_row;
  logic [1:0]    s_grp;

  logic          d_start, d_tile_done, d_tile_start, d_busy, d_done, d_error;
  logic [AW-1:0] d_addr;
  logic [4:0]    d_cnt;
  logic [4:0]    d_col;
  logic [8:0]    d_row;
  logic [0:0]    d_grp;

  ofm_tile_scheduler #(.SYSTOLIC_SIZE(S_SS), .OFM_SIZE(S_OFM), .NO_FILTER(S_NF),
                       .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(S_TO)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .tile_done(s_tile_done),
    .tile_start(s_tile_start), .ofm_base_addr(s_addr), .tile_valid_cnt(s_cnt),
    .tile_col(s_col), .tile_row(s_row), .filter_grp(s_grp),
    .busy(s_busy), .done(s_done), .error(s_error));

  ofm_tile_scheduler u_dflt (
    .clk(clk), .rst_n(rst_n), .start(d_start), .tile_done(d_tile_done),
    .tile_start(d_tile_start), .ofm_base_addr(d_addr), .tile_valid_cnt(d_cnt),
    .tile_col(d_col), .tile_row(d_row), .filter_grp(d_grp),
    .busy(d_busy), .done(d_done), .error(d_error));

  int nerr = 0, nchk = 0;
  tile_t s_q[$], d_q[$];
  int s_tiles = 0, s_dones = 0, d_tiles = 0, d_dones = 0, d_last_addr = -1;
  int epoch = 0;
  bit s_resp_en = 1'b1, s_inject = 1'b0, s_rand = 1'b0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_tile(input string p, input tile_t a, input tile_t e);
    check(a.addr == e.addr, {p, "_addr"}, a.addr, e.addr);
    check(a.cnt  == e.cnt,  {p, "_cnt"},  a.cnt,  e.cnt);
    check(a.col  == e.col,  {p, "_col"},  a.col,  e.col);
    check(a.row  == e.row,  {p, "_row"},  a.row,  e.row);
    check(a.grp  == e.grp,  {p, "_grp"},  a.grp,  e.grp);
  endtask

  function automatic int ntiles(input int ss, input int ofm, input int nf);
    return ((ofm + ss - 1) / ss) * ofm * (nf / ss);
  endfunction

  // Reference: tile index -> (grp,row,col) with col innermost, address from the closed-form formula.
  function automatic tile_t ref_tile(input int ss, input int ofm, input int nf, input int idx);
    tile_t t;
    int ncol;
    ncol   = (ofm + ss - 1) / ss;
    t.col  = idx % ncol;
    t.row  = (idx / ncol) % ofm;
    t.grp  = idx / (ncol * ofm);
    t.addr = (t.grp * ss * ofm * ofm + t.row * ofm + t.col * ss) % (1 << AW);
    t.cnt  = (t.col == ncol - 1) ? ofm - (ncol - 1) * ss : ss;
    return t;
  endfunction

  function automatic logic [63:0] s_outs();
    return 64'({s_tile_start, s_addr, s_cnt, s_col, s_row, s_grp, s_busy, s_done, s_error});
  endfunction

  function automatic logic [63:0] d_outs();
    return 64'({d_tile_start, d_addr, d_cnt, d_col, d_row, d_grp, d_busy, d_done, d_error});
  endfunction

  // Monitors
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_tile_start) begin
        s_tiles++;
        check(s_q.size() != 0, "s_tile_expected", s_q.size(), 1);
        if (s_q.size() != 0)
          chk_tile("s_tile", '{int'(s_addr), int'(s_cnt), int'(s_col), int'(s_row), int'(s_grp)},
                   s_q.pop_front());
        check({s_busy, s_error, s_done} == 3'b100, "s_issue_flags", {s_busy, s_error, s_done}, 3'b100);
      end
      if (s_done) begin
        s_dones++;
        check(s_q.size() == 0, "s_done_after_last_tile", s_q.size(), 0);
        check(s_busy == 1'b0, "s_busy_falls_with_done", s_busy, 0);
      end
      if (d_tile_start) begin
        d_tiles++;
        d_last_addr = int'(d_addr);
        check(d_q.size() != 0, "d_tile_expected", d_q.size(), 1);
        if (d_q.size() != 0)
          chk_tile("d_tile", '{int'(d_addr), int'(d_cnt), int'(d_col), int'(d_row), int'(d_grp)},
                   d_q.pop_front());
      end
      if (d_done) begin
        d_dones++;
        check(d_busy == 1'b0, "d_busy_falls_with_done", d_busy, 0);
      end
    end
  end

  // Small-instance responder: answers each tile_start after a delay, optionally also pulsing tile_done in ISSUE.
  initial begin
    int ep, dly;
    bit early;
    s_tile_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && s_tile_start && s_resp_en) begin
        ep    = epoch;
        early = 1'b0;
        dly   = s_rand ? int'($urandom_range(3, 8)) : 5;
        if (s_inject) s_tile_done = 1'b1;
        @(posedge clk);
        #1 s_tile_done = 1'b0;
        for (int i = 1; i < dly; i++) begin
          @(negedge clk);
          if (s_tile_start) early = 1'b1;
          @(posedge clk);
          #1;
        end
        if (ep == epoch) begin
          check(!early, "s_no_tile_before_done", early, 0);
          s_tile_done = 1'b1;
          @(posedge clk);
          #1 s_tile_done = 1'b0;
        end
      end
    end
  end

  // Default-instance responder: tile_done one cycle after each tile_start.
  initial begin
    d_tile_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && d_tile_start) begin
        @(posedge clk);
        #1 d_tile_done = 1'b1;
        @(posedge clk);
        #1 d_tile_done = 1'b0;
      end
    end
  end

  task automatic start_small();
    for (int i = 0; i < ntiles(S_SS, S_OFM, S_NF); i++)
      s_q.push_back(ref_tile(S_SS, S_OFM, S_NF, i));
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    check(s_tile_start == 1'b1 && s_busy == 1'b1, "s_first_issue_latency", {s_tile_start, s_busy}, 3);
  endtask

  task automatic wait_small_done(input int dones0, input int tiles0, input string name);
    int cyc = 0;
    while (s_dones == dones0 && cyc < 3000) begin
      @(posedge clk);
      #1 cyc++;
    end
    check(s_dones == dones0 + 1, {name, "_done"}, s_dones, dones0 + 1);
    repeat (20) @(posedge clk);
    #1;
    check(s_dones == dones0 + 1, {name, "_single_done"}, s_dones, dones0 + 1);
    check(s_tiles - tiles0 == 20, {name, "_tile_count"}, s_tiles - tiles0, 20);
    check(s_busy == 1'b0, {name, "_idle_busy"}, s_busy, 0);
  endtask

  task automatic wait_tiles(input int target, input string name);
    int cyc = 0;
    while (s_tiles < target && cyc < 3000) begin
      @(posedge clk);
      #1 cyc++;
    end
    check(s_tiles >= target, name, s_tiles, target);
  endtask

  initial begin
    int t0, d0, cyc;
    rst_n = 1'b0;
    s_start = 1'b0;
    d_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(s_outs() == 64'd0, "s_reset_outputs", s_outs(), 0);
    check(d_outs() == 64'd0, "d_reset_outputs", d_outs(), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full sweep, fixed 5-cycle response
    t0 = s_tiles; d0 = s_dones;
    start_small();
    wait_small_done(d0, t0, "sweep");

    // tile_done during ISSUE and start mid-layer, random response delays
    s_inject = 1'b1; s_rand = 1'b1;
    t0 = s_tiles; d0 = s_dones;
    start_small();
    wait_tiles(t0 + int'($urandom_range(2, 17)), "ign_reach_mid");
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    wait_small_done(d0, t0, "ignored");
    s_inject = 1'b0; s_rand = 1'b0;

    // Async reset in WAIT after tile 7, then a clean restart
    t0 = s_tiles;
    start_small();
    wait_tiles(t0 + 7, "rst_reach_tile7");
    @(posedge clk);
    #1 rst_n = 1'b0;
    epoch++;
    #1;
    check(s_outs() == 64'd0, "s_async_reset_outputs", s_outs(), 0);
    s_q.delete();
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    t0 = s_tiles; d0 = s_dones;
    start_small();
    wait_small_done(d0, t0, "after_reset");

`ifdef TILE_TIMEOUT_EN
    // Withheld tile_done: watchdog fires after the 10th WAIT cycle
    s_resp_en = 1'b0;
    d0 = s_dones;
    start_small();
    for (int i = 1; i <= S_TO; i++) begin
      @(posedge clk);
      #1;
      check(s_error == 1'b0 && s_busy == 1'b1, "to_waiting", {s_error, s_busy}, 1);
    end
    @(posedge clk);
    #1;
    check(s_error == 1'b1 && s_busy == 1'b0, "to_fired", {s_error, s_busy}, 2);
    repeat (10) @(posedge clk);
    #1;
    check(s_error == 1'b1 && s_tile_start == 1'b0, "to_sticky_idle", {s_error, s_tile_start}, 2);
    check(s_dones == d0, "to_no_done", s_dones, d0);
    s_q.delete();
    s_resp_en = 1'b1;
    t0 = s_tiles;
    start_small();
    check(s_error == 1'b0, "to_error_cleared", s_error, 0);
    wait_small_done(d0, t0, "after_timeout");
`endif

    // Default parameters, full layer
    for (int i = 0; i < ntiles(D_SS, D_OFM, D_NF); i++)
      d_q.push_back(ref_tile(D_SS, D_OFM, D_NF, i));
    d_start = 1'b1;
    @(posedge clk);
    #1 d_start = 1'b0;
    cyc = 0;
    while (d_dones == 0 && cyc < 60000) begin
      @(posedge clk);
      #1 cyc++;
    end
    check(d_dones == 1, "d_done", d_dones, 1);
    check(d_tiles == 10764, "d_tile_count", d_tiles, 10764);
    check(d_last_addr == 171382, "d_last_addr", d_last_addr, 171382);
    check(d_q.size() == 0, "d_all_tiles", d_q.size(), 0);
    check(d_error == 1'b0 && s_busy == 1'b0, "final_idle", {d_error, s_busy}, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
